// File: rtl/popcount_pkg.sv
// -----------------------------------------------------------------------------
// popcount_pkg
// Shared definitions for the popcount_stream block:
//   - mode_e           : per-beat counting mode (count ones / count zeros)
//   - DEFAULT_*        : default parameter values used by the block and its
//                        sub-module
//   - beat_cnt_width() : width needed to hold the bit count of one beat
//   - chunk_cnt_width(): width needed to hold the bit count of one chunk
// -----------------------------------------------------------------------------
package popcount_pkg;

  typedef enum logic {
    MODE_ONES  = 1'b0,
    MODE_ZEROS = 1'b1
  } mode_e;

  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_CHUNK_WIDTH = 8;
  localparam int DEFAULT_ACC_WIDTH   = 16;

  // A beat of W bits can contain anywhere from 0 to W set bits, so W itself
  // must be representable: $clog2(W)+1 bits.
  function automatic int beat_cnt_width(input int data_width);
    return $clog2(data_width) + 1;
  endfunction

  // Same reasoning for a chunk: values 0..W need $clog2(W+1) bits.
  function automatic int chunk_cnt_width(input int chunk_width);
    return $clog2(chunk_width + 1);
  endfunction

endpackage : popcount_pkg

// File: rtl/popcount_chunk.sv
// -----------------------------------------------------------------------------
// popcount_chunk
// Purely combinational count of set bits in one CHUNK_WIDTH-bit slice.
//
// Parameters:
//   CHUNK_WIDTH : width of the slice being counted
//   CNT_WIDTH   : width of the count output (defaults to the minimum needed)
//
// Ports:
//   data_i  in  CHUNK_WIDTH  slice to count
//   count_o out CNT_WIDTH    number of '1' bits in data_i
// -----------------------------------------------------------------------------
module popcount_chunk
  import popcount_pkg::*;
#(
  parameter int CHUNK_WIDTH = DEFAULT_CHUNK_WIDTH,
  parameter int CNT_WIDTH   = chunk_cnt_width(CHUNK_WIDTH)
) (
  input  logic [CHUNK_WIDTH-1:0] data_i,
  output logic [CNT_WIDTH-1:0]   count_o
);

  always_comb begin
    // NOTE: the output gets a default before the loop so that every path
    // assigns it; without that, synthesis would infer a latch.
    count_o = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      count_o = count_o + CNT_WIDTH'(data_i[i]);
    end
  end

endmodule : popcount_chunk

// File: rtl/popcount_stream.sv
// -----------------------------------------------------------------------------
// popcount_stream
// Streams packets of DATA_WIDTH-bit beats and produces, per packet, the total
// number of ones (in_mode=0) or zeros (in_mode=1) across all beats. The mode
// is sampled per beat, so a packet may mix modes.
//
// Pipeline:
//   stage 1 : per-chunk counts (one popcount_chunk per chunk), valid, last
//   stage 2 : chunk counts summed into a beat count and added to the packet
//             accumulator; the first beat of a packet ignores the old value
//   output  : result register loaded when stage 2 holds a last beat
// A last beat accepted at edge T shows up on out_valid after edge T+2.
// A pending, unconsumed result stalls the entire pipeline.
//
// Configuration macro:
//   POPCOUNT_SAT_EN : defined   -> accumulator clamps at 2^ACC_WIDTH-1 and
//                                  out_sat flags the packet (sticky to end)
//                     undefined -> accumulator wraps, out_sat tied to 0
//
// Parameters:
//   DATA_WIDTH  : beat width (multiple of CHUNK_WIDTH)
//   CHUNK_WIDTH : stage-1 chunk width
//   ACC_WIDTH   : packet count width (>= $clog2(DATA_WIDTH)+1)
//
// Ports:
//   clk        in  1           rising-edge clock
//   rst_n      in  1           asynchronous active-low reset
//   in_valid   in  1           beat offered
//   in_ready   out 1           beat accepted when in_valid & in_ready
//   in_data    in  DATA_WIDTH  beat payload
//   in_last    in  1           final beat of packet
//   in_mode    in  1           0 = count ones, 1 = count zeros
//   out_valid  out 1           packet result available
//   out_ready  in  1           result consumed when out_valid & out_ready
//   out_count  out ACC_WIDTH   packet bit count
//   out_sat    out 1           packet count saturated
// -----------------------------------------------------------------------------
module popcount_stream
  import popcount_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int CHUNK_WIDTH = DEFAULT_CHUNK_WIDTH,
  parameter int ACC_WIDTH   = DEFAULT_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_count,
  output logic                  out_sat
);

  localparam int NUM_CHUNKS      = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CHUNK_CNT_WIDTH = chunk_cnt_width(CHUNK_WIDTH);
  localparam int BEAT_CNT_WIDTH  = beat_cnt_width(DATA_WIDTH);

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic stall;
  logic out_valid_q;

  // A result that is offered but not taken freezes every stage; otherwise the
  // output register would be overwritten by the next packet.
  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  // ---------------------------------------------------------------------------
  // Stage 1: per-chunk counts
  // ---------------------------------------------------------------------------
  mode_e                      mode;
  logic [CHUNK_CNT_WIDTH-1:0] chunk_ones  [NUM_CHUNKS];
  logic [CHUNK_CNT_WIDTH-1:0] chunk_cnt_d [NUM_CHUNKS];
  logic [CHUNK_CNT_WIDTH-1:0] s1_cnt_q    [NUM_CHUNKS];
  logic                       s1_valid_q;
  logic                       s1_last_q;

  assign mode = mode_e'(in_mode);

  for (genvar c = 0; c < NUM_CHUNKS; c++) begin : g_chunk
    popcount_chunk #(
      .CHUNK_WIDTH (CHUNK_WIDTH),
      .CNT_WIDTH   (CHUNK_CNT_WIDTH)
    ) u_chunk (
      .data_i  (in_data[c*CHUNK_WIDTH +: CHUNK_WIDTH]),
      .count_o (chunk_ones[c])
    );
  end

  // Zeros in a chunk are simply the chunk width minus its ones, so a single
  // ones-counter serves both modes.
  always_comb begin
    for (int c = 0; c < NUM_CHUNKS; c++) begin
      chunk_cnt_d[c] = chunk_ones[c];
      if (mode == MODE_ZEROS) begin
        chunk_cnt_d[c] = CHUNK_CNT_WIDTH'(CHUNK_WIDTH) - chunk_ones[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state registers use non-blocking assignments so that every
      // flop samples the values from before the clock edge.
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      for (int c = 0; c < NUM_CHUNKS; c++) begin
        s1_cnt_q[c] <= '0;
      end
    end else if (!stall) begin
      s1_valid_q <= in_valid;
      // Payload is only captured for a real beat, so idle-cycle data never
      // moves through the pipe.
      if (in_valid) begin
        s1_last_q <= in_last;
        for (int c = 0; c < NUM_CHUNKS; c++) begin
          s1_cnt_q[c] <= chunk_cnt_d[c];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: beat sum and packet accumulator
  // ---------------------------------------------------------------------------
  logic [BEAT_CNT_WIDTH-1:0] beat_cnt;
  logic [ACC_WIDTH-1:0]      acc_base;
  logic [ACC_WIDTH-1:0]      acc_d;
  logic [ACC_WIDTH-1:0]      acc_q;
  logic                      pkt_start_q;
  logic                      s2_valid_q;
  logic                      s2_last_q;
`ifdef POPCOUNT_SAT_EN
  logic [ACC_WIDTH:0]        acc_sum_wide;
  logic                      sat_d;
  logic                      sat_q;
`endif

  always_comb begin
    beat_cnt = '0;
    for (int c = 0; c < NUM_CHUNKS; c++) begin
      beat_cnt = beat_cnt + BEAT_CNT_WIDTH'(s1_cnt_q[c]);
    end

    // acc_q still holds the previous packet's total after its last beat;
    // pkt_start_q masks it instead of spending a cycle clearing it.
    acc_base = pkt_start_q ? '0 : acc_q;

`ifdef POPCOUNT_SAT_EN
    // One extra bit catches the carry out; once set, the flag stays for the
    // rest of the packet and the value stays pinned at all-ones.
    acc_sum_wide = {1'b0, acc_base} + (ACC_WIDTH+1)'(beat_cnt);
    sat_d        = (!pkt_start_q && sat_q) || acc_sum_wide[ACC_WIDTH];
    acc_d        = sat_d ? '1 : acc_sum_wide[ACC_WIDTH-1:0];
`else
    acc_d = acc_base + ACC_WIDTH'(beat_cnt);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      acc_q       <= '0;
      pkt_start_q <= 1'b1;
`ifdef POPCOUNT_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else if (!stall) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_last_q   <= s1_last_q;
        acc_q       <= acc_d;
        pkt_start_q <= s1_last_q;
`ifdef POPCOUNT_SAT_EN
        sat_q       <= sat_d;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic                 result_load;
  logic [ACC_WIDTH-1:0] out_count_q;

  assign result_load = s2_valid_q & s2_last_q;

  // When not stalled, either nothing is pending or the pending result is
  // being consumed this cycle, so out_valid can drop and rise again with the
  // next packet in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_count_q <= '0;
    end else if (!stall) begin
      out_valid_q <= result_load;
      if (result_load) begin
        out_count_q <= acc_q;
      end
    end
  end

`ifdef POPCOUNT_SAT_EN
  logic out_sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sat_q <= 1'b0;
    end else if (!stall && result_load) begin
      out_sat_q <= sat_q;
    end
  end

  assign out_sat = out_sat_q;
`else
  assign out_sat = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign out_count = out_count_q;

endmodule : popcount_stream

// File: tb/tb_popcount_stream.sv
// -----------------------------------------------------------------------------
// tb_popcount_stream
// Self-checking bench for popcount_stream. A 32/8/16 instance carries the
// directed sequences, a table of back-to-back single-beat packets and a
// random phase; an ACC_WIDTH=8 instance covers saturation/wrap. Build with or
// without POPCOUNT_SAT_EN; expectations follow the macro.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_popcount_stream;

  localparam longint ACC_MAX = 65535;

  typedef struct {
    longint cnt;
    logic   sat;
  } res_t;

  typedef struct {
    logic [31:0] data;
    logic        mode;
    longint      exp;
  } vec_t;

  logic        clk;
  logic        rst_n;

  // 32/8/16 instance
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_count;
  logic        out_sat;

  // ACC_WIDTH=8 instance
  logic        b_in_valid;
  logic        b_in_ready;
  logic [31:0] b_in_data;
  logic        b_in_last;
  logic        b_in_mode;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [7:0]  b_out_count;
  logic        b_out_sat;

  int          n_tests;
  int          n_fail;

  res_t        exp_q[$];
  longint      m_sum;
  int          m_ones;
  res_t        m_res;
  vec_t        tbl[9];

  popcount_stream #(
    .DATA_WIDTH  (32),
    .CHUNK_WIDTH (8),
    .ACC_WIDTH   (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_sat   (out_sat)
  );

  popcount_stream #(
    .DATA_WIDTH  (32),
    .CHUNK_WIDTH (8),
    .ACC_WIDTH   (8)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .in_last   (b_in_last),
    .in_mode   (b_in_mode),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_count (b_out_count),
    .out_sat   (b_out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Move to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call just after a rising edge; returns just after the edge that accepted
  // the beat.
  task automatic drive_beat(input logic [31:0] d, input logic l, input logic m);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_mode  = m;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("drive_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input longint exp_cnt);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!out_valid) check({name, "_timeout"}, 0, 1);
    else            check(name, longint'(out_count), exp_cnt);
  endtask

  // Reference model and scoreboard: packet totals from $countones, sampled
  // at the falling edge where handshakes are stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_sum = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          m_res = exp_q.pop_front();
          check("sb_count", longint'(out_count), m_res.cnt);
          check("sb_sat", longint'(out_sat), longint'(m_res.sat));
        end
      end
      if (in_valid && in_ready) begin
        m_ones = $countones(in_data);
        m_sum  = m_sum + (in_mode ? longint'(32 - m_ones) : longint'(m_ones));
        if (in_last) begin
`ifdef POPCOUNT_SAT_EN
          if (m_sum > ACC_MAX) m_res = '{ACC_MAX, 1'b1};
          else                 m_res = '{m_sum, 1'b0};
`else
          m_res = '{m_sum % (ACC_MAX + 1), 1'b0};
`endif
          exp_q.push_back(m_res);
          m_sum = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;

    tbl[0] = '{32'h0000_0000, 1'b0, 0};
    tbl[1] = '{32'hFFFF_FFFF, 1'b0, 32};
    tbl[2] = '{32'hFFFF_FFFF, 1'b1, 0};
    tbl[3] = '{32'h0000_0000, 1'b1, 32};
    tbl[4] = '{32'h8000_0001, 1'b0, 2};
    tbl[5] = '{32'h0000_000F, 1'b1, 28};
    tbl[6] = '{32'hF0F0_F0F0, 1'b0, 16};
    tbl[7] = '{32'h1234_5678, 1'b0, 13};
    tbl[8] = '{32'hAAAA_AAAA, 1'b1, 16};

    n_tests     = 0;
    n_fail      = 0;
    m_sum       = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    in_mode     = 1'b0;
    out_ready   = 1'b1;
    b_in_valid  = 1'b0;
    b_in_data   = '0;
    b_in_last   = 1'b0;
    b_in_mode   = 1'b0;
    b_out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_count", longint'(out_count), 0);
    check("rst_out_sat", longint'(out_sat), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    step();
    rst_n = 1'b1;

    // Single all-ones beat: exact two-cycle latency
    step();
    drive_beat(32'hFFFF_FFFF, 1'b1, 1'b0);
    @(negedge clk);
    check("lat_after_T", longint'(out_valid), 0);
    @(negedge clk);
    check("lat_after_T1", longint'(out_valid), 0);
    @(negedge clk);
    check("lat_after_T2", longint'(out_valid), 1);
    check("single_ones_count", longint'(out_count), 32);

    // Three-beat zeros packet
    step();
    drive_beat(32'h0000_000F, 1'b0, 1'b1);
    drive_beat(32'hF0F0_F0F0, 1'b0, 1'b1);
    drive_beat(32'h0000_0000, 1'b1, 1'b1);
    wait_result("three_beat_zeros", 76);

    // Back-pressure: result held, input blocked, offered beat not lost
    step();
    out_ready = 1'b0;
    drive_beat(32'h0000_00FF, 1'b1, 1'b0);
    guard = 0;
    @(negedge clk);
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!out_valid) check("stall_result_timeout", 0, 1);
    in_valid = 1'b1;
    in_data  = 32'h0000_0007;
    in_last  = 1'b1;
    in_mode  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall_in_ready", longint'(in_ready), 0);
      check("stall_out_valid", longint'(out_valid), 1);
      check("stall_out_count", longint'(out_count), 8);
      @(negedge clk);
    end
    step();
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    wait_result("after_stall_count", 3);

    // Reset in the middle of a packet
    step();
    drive_beat(32'h0000_FFFF, 1'b0, 1'b0);
    drive_beat(32'h0000_00FF, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_out_count", longint'(out_count), 0);
    check("midrst_out_sat", longint'(out_sat), 0);
    check("midrst_in_ready", longint'(in_ready), 1);
    step();
    rst_n = 1'b1;
    drive_beat(32'h0000_0001, 1'b1, 1'b0);
    wait_result("post_reset_count", 1);

    // Table: single-beat packets every cycle, results back to back
    step();
    fork
      begin
        for (int i = 0; i < 9; i++) begin
          drive_beat(tbl[i].data, 1'b1, tbl[i].mode);
        end
      end
      begin
        int g;
        g = 0;
        @(negedge clk);
        while (!out_valid && g < 20) begin
          @(negedge clk);
          g++;
        end
        for (int i = 0; i < 9; i++) begin
          check($sformatf("tbl%0d_valid", i), longint'(out_valid), 1);
          check($sformatf("tbl%0d_count", i), longint'(out_count), tbl[i].exp);
          @(negedge clk);
        end
      end
    join

    // Random traffic against the model
    for (int cyc = 0; cyc < 1500; cyc++) begin
      step();
      in_valid = ($urandom_range(3) != 0);
      case ($urandom_range(3))
        0:       in_data = '0;
        1:       in_data = '1;
        default: in_data = $urandom;
      endcase
      in_last   = ($urandom_range(3) == 0);
      in_mode   = 1'($urandom_range(1));
      out_ready = ($urandom_range(3) != 0);
    end
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) step();
    check("drain_queue", longint'(exp_q.size()), 0);

    // Narrow accumulator: 9 all-ones beats = 288
    step();
    for (int k = 0; k < 9; k++) begin
      b_in_valid = 1'b1;
      b_in_data  = '1;
      b_in_mode  = 1'b0;
      b_in_last  = (k == 8);
      step();
    end
    b_in_valid = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!b_out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("acc8_valid", longint'(b_out_valid), 1);
`ifdef POPCOUNT_SAT_EN
    check("acc8_count", longint'(b_out_count), 255);
    check("acc8_sat", longint'(b_out_sat), 1);
`else
    check("acc8_count", longint'(b_out_count), 32);
    check("acc8_sat", longint'(b_out_sat), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_popcount_stream

// File: doc/popcount_stream.md
POPCOUNT_STREAM -- requirements
Module: popcount_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, input beat width in bits.
REQ-002 SHALL have parameter CHUNK_WIDTH, default 8, stage-1 chunk width; DATA_WIDTH SHALL be a multiple of CHUNK_WIDTH.
REQ-003 SHALL have parameter ACC_WIDTH, default 16, packet count width; ACC_WIDTH SHALL be at least $clog2(DATA_WIDTH)+1.
REQ-004 SHALL have ports:
  clk  in  1  single clock, rising edge
  rst_n  in  1  asynchronous, active-low reset
  in_valid  in  1  beat offered
  in_ready  out  1  beat accepted when in_valid & in_ready
  in_data  in  DATA_WIDTH  beat payload
  in_last  in  1  final beat of packet
  in_mode  in  1  0 = count ones, 1 = count zeros; sampled per beat
  out_valid  out  1  packet result available
  out_ready  in  1  result consumed when out_valid & out_ready
  out_count  out  ACC_WIDTH  packet bit count
  out_sat  out  1  packet count saturated

Function
REQ-005 SHALL, in stage 1, register per-chunk counts of DATA_WIDTH/CHUNK_WIDTH chunks (zeros counted as CHUNK_WIDTH minus ones when in_mode=1), plus valid, last.
REQ-006 SHALL, in stage 2, sum chunk counts into a beat count of $clog2(DATA_WIDTH)+1 bits and add it to the packet accumulator.
REQ-007 SHALL start each packet at 0: the first beat after reset or after a last beat ignores the previous accumulator value.
REQ-008 SHALL, on a last beat in stage 2, load out_count/out_sat with the final sum, set out_valid, and clear accumulator for the next packet.
REQ-009 SHALL have latency 2: last beat accepted at edge T gives out_valid high after edge T+2.
REQ-010 SHALL hold out_valid, out_count, out_sat stable until out_valid & out_ready.
REQ-011 SHALL stall the whole pipeline when out_valid & ~out_ready; in_ready = ~(out_valid & ~out_ready), combinational.
REQ-012 SHALL sustain one accepted beat per cycle and one packet result per cycle (single-beat packets) while out_ready=1.
REQ-013 SHALL allow out_valid to deassert and reassert with a new result in the same cycle as a handshake (no bubble).
REQ-014 SHALL ignore in_data, in_last, in_mode when in_valid=0.

Reset
REQ-015 SHALL, on rst_n low, immediately clear out_valid, out_count, out_sat, stage valids, accumulator, and set packet-start state; in_ready=1 while out_valid=0.
REQ-016 SHALL discard any partial packet on reset; no result is emitted for it.

Configuration
REQ-017 SHALL, with POPCOUNT_SAT_EN defined, clamp accumulator at 2^ACC_WIDTH-1 and set out_sat for that packet (sticky to packet end).
REQ-018 SHALL, without POPCOUNT_SAT_EN, wrap accumulator modulo 2^ACC_WIDTH and tie out_sat to 0.

Structure
REQ-019 SHALL take from shared package popcount_pkg: mode typedef (ones/zeros), beat-count width function, default parameter constants.
REQ-020 SHALL instantiate sub-module popcount_chunk (combinational ones count of CHUNK_WIDTH bits) once per chunk.

Verification (DATA_WIDTH=32, CHUNK_WIDTH=8, ACC_WIDTH=16 unless stated)
REQ-021 Single beat 0xFFFF_FFFF, in_last=1, mode 0 -> out_count=32, out_valid 2 cycles after acceptance.
REQ-022 Three beats 0x0000_000F, 0xF0F0_F0F0, 0x0000_0000(last), mode 1 -> out_count=28+16+32=76.
REQ-023 Result pending, out_ready low 5 cycles -> in_ready low, out_count stable, no beat lost; next packet correct.
REQ-024 ACC_WIDTH=8, 9 all-ones beats -> with POPCOUNT_SAT_EN 255, out_sat=1; without, 32, out_sat=0.
REQ-025 rst_n low after 2 beats of a packet -> all outputs 0, no result; following packet 0x0000_0001 (last) gives 1.
REQ-026 Single-beat packets every cycle, out_ready=1 -> one result per cycle, in order, no bubbles.
